// File: rtl/bf_result_checker_if.sv
// Engine-side bus of the Bellman-Ford result checker: write-enable
// monitor, negative-cycle flags and the shared compare read port.
interface bf_result_checker_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              OMWE;
    logic              NegCycle;
    logic              ExpNegCycle;
    logic [DATA_W-1:0] OMDR;
    logic [DATA_W-1:0] GOLDDR;
    logic [ADDR_W-1:0] CHKAR;

    modport master (
        output OMWE,
        output NegCycle,
        output ExpNegCycle,
        output OMDR,
        output GOLDDR,
        input  CHKAR
    );

    modport slave (
        input  OMWE,
        input  NegCycle,
        input  ExpNegCycle,
        input  OMDR,
        input  GOLDDR,
        output CHKAR
    );
endinterface

// File: rtl/bf_result_checker.sv
// End-of-run checker: waits for the engine to go quiet, then walks the
// output and golden memories in lockstep and reports a verdict.
module bf_result_checker #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int NUM_ENTRIES = 8192,
    parameter int IDLE_CYCLES = 1024,
    parameter int TIMEOUT     = 2000000
) (
    input  logic                clock,
    input  logic                reset,
    bf_result_checker_if.slave  bus,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic                TimedOut,
    output logic [ADDR_W:0]     ErrCount,
    output logic [ADDR_W-1:0]   FirstErrAddr,
    output logic                FirstErrValid
);
    localparam int RUN_W  = $clog2(TIMEOUT + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {
        MONITOR,
        SCAN,
        REPORT
    } state_t;

    state_t            state, state_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [ADDR_W:0]   err_cnt, err_n;
    logic [ADDR_W-1:0] first_addr, first_addr_n;
    logic              first_vld, first_vld_n;
    logic              timed_out, timed_out_n;
    logic              pass, pass_n;
    logic              idle_hit, run_hit, last_addr;

    // Quiet-period and run-length thresholds; run uses >= so a scan
    // aborted after the limit still times out on the next MONITOR cycle.
    assign idle_hit  = !bus.OMWE &&
                       (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
    assign run_hit   = (run_cnt >= RUN_W'(TIMEOUT - 1));
    assign last_addr = (addr == ADDR_W'(NUM_ENTRIES - 1));

    // Next-state and datapath updates for all three phases
    always_comb begin
        state_n      = state;
        idle_n       = idle_cnt;
        run_n        = run_cnt;
        addr_n       = addr;
        err_n        = err_cnt;
        first_addr_n = first_addr;
        first_vld_n  = first_vld;
        timed_out_n  = timed_out;
        pass_n       = pass;
        unique case (state)
            MONITOR: begin
                idle_n = bus.OMWE ? '0 : idle_cnt + IDLE_W'(1);
                run_n  = run_cnt + RUN_W'(1);
                if (idle_hit) begin
                    state_n = SCAN;
                    addr_n  = '0;
                end else if (run_hit) begin
                    state_n     = REPORT;
                    timed_out_n = 1'b1;
                    pass_n      = 1'b0;
                end
            end
            SCAN: begin
                if (bus.OMWE) begin
                    state_n      = MONITOR;
                    addr_n       = '0;
                    err_n        = '0;
                    first_addr_n = '0;
                    first_vld_n  = 1'b0;
                    idle_n       = '0;
                end else begin
                    if (bus.OMDR != bus.GOLDDR) begin
                        if (err_cnt != '1) begin
                            err_n = err_cnt + (ADDR_W + 1)'(1);
                        end
                        if (!first_vld) begin
                            first_addr_n = addr;
                            first_vld_n  = 1'b1;
                        end
                    end
                    if (last_addr) begin
                        state_n = REPORT;
                        addr_n  = '0;
                        pass_n  = (err_n == '0) &&
                                  (bus.NegCycle == bus.ExpNegCycle);
                    end else begin
                        addr_n = addr + ADDR_W'(1);
                    end
                end
            end
            REPORT: begin
                state_n = REPORT;
            end
            default: begin
                state_n = MONITOR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= MONITOR;
            idle_cnt   <= '0;
            run_cnt    <= '0;
            addr       <= '0;
            err_cnt    <= '0;
            first_addr <= '0;
            first_vld  <= 1'b0;
            timed_out  <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            idle_cnt   <= idle_n;
            run_cnt    <= run_n;
            addr       <= addr_n;
            err_cnt    <= err_n;
            first_addr <= first_addr_n;
            first_vld  <= first_vld_n;
            timed_out  <= timed_out_n;
            pass       <= pass_n;
        end
    end

    assign bus.CHKAR     = addr;
    assign Busy          = (state != REPORT);
    assign Done          = (state == REPORT);
    assign Pass          = pass;
    assign TimedOut      = timed_out;
    assign ErrCount      = err_cnt;
    assign FirstErrAddr  = first_addr;
    assign FirstErrValid = first_vld;
endmodule

// File: tb/tb_bf_result_checker.sv
// Directed bench for bf_result_checker with 16 entries, an 8-cycle
// idle window and a 100-cycle timeout.
module tb_bf_result_checker;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int N      = 16;

    logic              clock;
    logic              reset;
    logic              Busy, Done, Pass, TimedOut, FirstErrValid;
    logic [ADDR_W:0]   ErrCount;
    logic [ADDR_W-1:0] FirstErrAddr;
    logic [DATA_W-1:0] out_mem  [N];
    logic [DATA_W-1:0] gold_mem [N];
    int                total = 0;
    int                bad   = 0;
    logic              scan_seen;

    bf_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.OMDR   = out_mem[bus.CHKAR];
    assign bus.GOLDDR = gold_mem[bus.CHKAR];

    bf_result_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .NUM_ENTRIES(N),
        .IDLE_CYCLES(8),
        .TIMEOUT(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .Busy(Busy),
        .Done(Done),
        .Pass(Pass),
        .TimedOut(TimedOut),
        .ErrCount(ErrCount),
        .FirstErrAddr(FirstErrAddr),
        .FirstErrValid(FirstErrValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill();
        for (int i = 0; i < N; i++) begin
            gold_mem[i] = 16'(i * 3 + 7);
            out_mem[i]  = gold_mem[i];
        end
    endtask

    task automatic do_reset();
        bus.OMWE        = 1'b0;
        bus.NegCycle    = 1'b0;
        bus.ExpNegCycle = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        fill();
        do_reset();

        // reset values
        chk("rst_busy", Busy, 1);
        chk("rst_done", Done, 0);
        chk("rst_chkar", bus.CHKAR, 0);
        chk("rst_err", ErrCount, 0);
        chk("rst_faddr", FirstErrAddr, 0);
        chk("rst_fvld", FirstErrValid, 0);
        chk("rst_pass", Pass, 0);
        chk("rst_to", TimedOut, 0);

        // match: OMWE on edges 3..10, Done at edge 34
        for (int e = 1; e <= 33; e++) begin
            bus.OMWE = (e >= 3 && e <= 10);
            tick();
            if (e == 20) chk("t1_chkar_mid", bus.CHKAR, 2);
        end
        bus.OMWE = 1'b0;
        chk("t1_done_early", Done, 0);
        tick();
        chk("t1_done", Done, 1);
        chk("t1_busy", Busy, 0);
        chk("t1_pass", Pass, 1);
        chk("t1_err", ErrCount, 0);
        chk("t1_fvld", FirstErrValid, 0);
        chk("t1_to", TimedOut, 0);
        chk("t1_chkar", bus.CHKAR, 0);

        // mismatches at 5 and 12, Done at edge 24
        fill();
        out_mem[5]  = out_mem[5] ^ 16'h0001;
        out_mem[12] = out_mem[12] ^ 16'h8000;
        do_reset();
        ticks(23);
        chk("t2_done_early", Done, 0);
        tick();
        chk("t2_done", Done, 1);
        chk("t2_err", ErrCount, 2);
        chk("t2_faddr", FirstErrAddr, 5);
        chk("t2_fvld", FirstErrValid, 1);
        chk("t2_pass", Pass, 0);

        // negative-cycle disagreement
        fill();
        do_reset();
        bus.NegCycle = 1'b1;
        ticks(24);
        chk("t3_done", Done, 1);
        chk("t3_pass", Pass, 0);
        chk("t3_err", ErrCount, 0);

        // negative-cycle agreement
        do_reset();
        bus.NegCycle    = 1'b1;
        bus.ExpNegCycle = 1'b1;
        ticks(24);
        chk("t3b_done", Done, 1);
        chk("t3b_pass", Pass, 1);

        // timeout: OMWE every 4 cycles for 200 cycles
        do_reset();
        scan_seen = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            bus.OMWE = (e % 4 == 0);
            tick();
            if (bus.CHKAR != '0) scan_seen = 1'b1;
            if (e == 99) chk("t4_done_early", Done, 0);
            if (e == 100) chk("t4_done", Done, 1);
        end
        bus.OMWE = 1'b0;
        chk("t4_done_held", Done, 1);
        chk("t4_to", TimedOut, 1);
        chk("t4_pass", Pass, 0);
        chk("t4_err", ErrCount, 0);
        chk("t4_noscan", scan_seen, 0);

        // abort at address 7 with a mismatch at address 3
        fill();
        out_mem[3] = out_mem[3] ^ 16'h0010;
        do_reset();
        ticks(15);
        chk("t5_pre_chkar", bus.CHKAR, 7);
        chk("t5_pre_err", ErrCount, 1);
        chk("t5_pre_faddr", FirstErrAddr, 3);
        bus.OMWE = 1'b1;
        tick();
        bus.OMWE = 1'b0;
        chk("t5_ab_err", ErrCount, 0);
        chk("t5_ab_fvld", FirstErrValid, 0);
        chk("t5_ab_busy", Busy, 1);
        chk("t5_ab_chkar", bus.CHKAR, 0);
        fill();
        out_mem[10] = out_mem[10] ^ 16'h0100;
        ticks(23);
        chk("t5_done_early", Done, 0);
        tick();
        chk("t5_done", Done, 1);
        chk("t5_err", ErrCount, 1);
        chk("t5_faddr", FirstErrAddr, 10);
        chk("t5_fvld", FirstErrValid, 1);
        chk("t5_pass", Pass, 0);
        chk("t5_to", TimedOut, 0);

        // reset mid-scan at address 9
        fill();
        out_mem[2] = out_mem[2] ^ 16'h0004;
        do_reset();
        ticks(17);
        chk("t6_pre_chkar", bus.CHKAR, 9);
        chk("t6_pre_err", ErrCount, 1);
        reset = 1'b1;
        tick();
        chk("t6_busy", Busy, 1);
        chk("t6_done", Done, 0);
        chk("t6_chkar", bus.CHKAR, 0);
        chk("t6_err", ErrCount, 0);
        chk("t6_fvld", FirstErrValid, 0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
